grom_arb: RTL and testbench

- Sequencer/arbiter in front of the grom ROM, a single-port ROM with synchronous read and 1-cycle latency.
- After reset it walks the entire ROM once, computes an XOR checksum and raises fin; the simulation top waits on fin before finishing.
- It then shares the ROM between two read requesters, A and B, with round-robin arbitration.

---
 rtl/grom_arb_if.sv | 46 ++++
 rtl/grom_arb.sv | 140 ++++++++++++++
 tb/tb_grom_arb.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grom_arb_if.sv
// Bus bundle between grom_arb and its surroundings: the ROM read port,
// the two requester handshakes, and the boot status outputs.
// The arbiter uses the slave modport; the ROM/requester side uses master.
interface grom_arb_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;

    logic          a_req;
    logic [AW-1:0] a_addr;
    logic          a_gnt;
    logic          a_valid;
    logic [DW-1:0] a_data;

    logic          b_req;
    logic [AW-1:0] b_addr;
    logic          b_gnt;
    logic          b_valid;
    logic [DW-1:0] b_data;

    logic          fin;
    logic [DW-1:0] csum;

    modport slave (
        input  rom_data,
        input  a_req, a_addr,
        input  b_req, b_addr,
        output rom_en, rom_addr,
        output a_gnt, a_valid, a_data,
        output b_gnt, b_valid, b_data,
        output fin, csum
    );

    modport master (
        output rom_data,
        output a_req, a_addr,
        output b_req, b_addr,
        input  rom_en, rom_addr,
        input  a_gnt, a_valid, a_data,
        input  b_gnt, b_valid, b_data,
        input  fin, csum
    );
endinterface

// File: rtl/grom_arb.sv
// grom_arb: boot-time checksum walker and two-port read arbiter for the
// grom ROM. The ROM data is consumed on the edge after the registered
// rom_en/rom_addr, so a grant produces valid data two cycles later.
//
// Optional build macro GROM_ARB_PRIO_EN: requester A has fixed priority
// over B. Without it, simultaneous requests alternate round-robin.
//
// state | meaning
// ------+-----------------------------------------------------------
// BOOT  | issuing ROM reads 0..DEPTH-1, folding returned words into csum
// DRAIN | folding the final boot word, raising fin
// RUN   | granting A/B requests and returning their read data
module grom_arb #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    grom_arb_if.slave  bus
);
    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        DRAIN = 2'd1,
        RUN   = 2'd2
    } state_t;

    // One extra bit so that DEPTH = 2**AW ends the walk without wrapping.
    localparam logic [AW:0] LAST_ADDR = (AW+1)'(DEPTH - 1);

    state_t        state;
    logic [AW:0]   boot_cnt;
    logic          boot_rd;
    logic          rd_a;
    logic          rd_b;
    logic          run_ok;
    logic          gnt_a;
    logic          gnt_b;
    logic          rom_en_q;
    logic [AW-1:0] rom_addr_q;
    logic          a_valid_q;
    logic          b_valid_q;
    logic [DW-1:0] a_data_q;
    logic [DW-1:0] b_data_q;
    logic          fin_q;
    logic [DW-1:0] csum_q;
`ifndef GROM_ARB_PRIO_EN
    logic          rr_last;    // 1: B was granted last, 0: A was
`endif

    // Grant decode; combinational so a requester sees gnt in its request cycle.
    always_comb begin
        run_ok = !rst && (state == RUN);
`ifdef GROM_ARB_PRIO_EN
        gnt_a  = run_ok && bus.a_req;
        gnt_b  = run_ok && bus.b_req && !bus.a_req;
`else
        gnt_a  = run_ok && bus.a_req && (!bus.b_req || rr_last);
        gnt_b  = run_ok && bus.b_req && (!bus.a_req || !rr_last);
`endif
    end

    assign bus.a_gnt    = gnt_a;
    assign bus.b_gnt    = gnt_b;
    assign bus.rom_en   = rom_en_q;
    assign bus.rom_addr = rom_addr_q;
    assign bus.a_valid  = a_valid_q;
    assign bus.b_valid  = b_valid_q;
    assign bus.a_data   = a_data_q;
    assign bus.b_data   = b_data_q;
    assign bus.fin      = fin_q;
    assign bus.csum     = csum_q;

    // Sequencer: boot walk, checksum fold, ROM issue and read-data return.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            boot_cnt   <= '0;
            boot_rd    <= 1'b0;
            rd_a       <= 1'b0;
            rd_b       <= 1'b0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= '0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            a_data_q   <= '0;
            b_data_q   <= '0;
            fin_q      <= 1'b0;
            csum_q     <= '0;
`ifndef GROM_ARB_PRIO_EN
            rr_last    <= 1'b1;
`endif
        end else begin
            // Return data for reads issued on the previous edge.
            a_valid_q <= rd_a;
            b_valid_q <= rd_b;
            if (rd_a) a_data_q <= bus.rom_data;
            if (rd_b) b_data_q <= bus.rom_data;
            // Only boot-walk reads touch csum, which freezes it after fin.
            if (boot_rd) csum_q <= csum_q ^ bus.rom_data;

            rd_a     <= 1'b0;
            rd_b     <= 1'b0;
            boot_rd  <= 1'b0;
            rom_en_q <= 1'b0;

            case (state)
                BOOT: begin
                    rom_en_q   <= 1'b1;
                    rom_addr_q <= boot_cnt[AW-1:0];
                    boot_rd    <= 1'b1;
                    boot_cnt   <= boot_cnt + 1'b1;
                    if (boot_cnt == LAST_ADDR) state <= DRAIN;
                end
                DRAIN: begin
                    fin_q <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    if (gnt_a) begin
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= bus.a_addr;
                        rd_a       <= 1'b1;
`ifndef GROM_ARB_PRIO_EN
                        rr_last    <= 1'b0;
`endif
                    end else if (gnt_b) begin
                        rom_en_q   <= 1'b1;
                        rom_addr_q <= bus.b_addr;
                        rd_b       <= 1'b1;
`ifndef GROM_ARB_PRIO_EN
                        rr_last    <= 1'b1;
`endif
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule

// File: tb/tb_grom_arb.sv
// Testbench for grom_arb: directed boot/reset sequences, a vector table
// for the arbitration pipeline, and randomized traffic against a
// queue-based reference model of the grant and read-return rules.
`timescale 1ns/1ps
module tb_grom_arb;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] rom [2**AW];
    int            errors = 0;
    int            checks = 0;
    logic          m_last = 1'b1;   // model: 1 means B was granted last

    grom_arb_if #(.AW(AW), .DW(DW)) bus ();

    grom_arb #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // ROM: data follows the registered address; a poison value when idle.
    assign bus.rom_data = bus.rom_en ? rom[bus.rom_addr] : 8'hA5;

    typedef struct {
        logic       ar, br;
        logic [3:0] aa, ba;
        logic       eag, ebg, een, eav, ebv;
        logic [7:0] ead, ebd;
    } vec_t;

    typedef struct {
        logic       side;
        logic [7:0] data;
        int         due;
    } rd_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ar, input logic [3:0] aa, input logic br, input logic [3:0] ba);
        bus.a_req  = ar;
        bus.a_addr = aa;
        bus.b_req  = br;
        bus.b_addr = ba;
    endtask

    function automatic vec_t mk(input logic ar, input logic br, input logic [3:0] aa,
                                input logic [3:0] ba, input logic eag, input logic ebg,
                                input logic een, input logic eav, input logic ebv,
                                input logic [7:0] ead, input logic [7:0] ebd);
        vec_t v;
        v.ar = ar; v.br = br; v.aa = aa; v.ba = ba;
        v.eag = eag; v.ebg = ebg; v.een = een; v.eav = eav; v.ebv = ebv;
        v.ead = ead; v.ebd = ebd;
        return v;
    endfunction

    // Grant rules as stated for the block, using the model's own history bit.
    function automatic void exp_grant(input logic ar, input logic br, output logic ga, output logic gb);
`ifdef GROM_ARB_PRIO_EN
        ga = ar;
        gb = br && !ar;
`else
        if (ar && br) begin
            ga = m_last;
            gb = !m_last;
        end else begin
            ga = ar;
            gb = br;
        end
`endif
    endfunction

    initial begin
        vec_t       tbl [14];
        rd_t        pend [$];
        rd_t        r;
        logic       ar, br, ega, egb, eva, evb;
        logic [3:0] aa, ba;
        logic [7:0] ead, ebd, mcsum;

        for (int i = 0; i < 2**AW; i++) rom[i] = 8'(i + 1);
        drive(1'b0, 4'd0, 1'b0, 4'd0);

        // ---------------- reset values ----------------
        rst = 1'b1;
        cyc();
        drive(1'b1, 4'd3, 1'b1, 4'd9);
        cyc();
        #1;
        chk("rst rom_en",  32'(bus.rom_en), 0);
        chk("rst rom_addr", 32'(bus.rom_addr), 0);
        chk("rst fin",     32'(bus.fin), 0);
        chk("rst csum",    32'(bus.csum), 0);
        chk("rst a_valid", 32'(bus.a_valid), 0);
        chk("rst b_valid", 32'(bus.b_valid), 0);
        chk("rst a_data",  32'(bus.a_data), 0);
        chk("rst b_data",  32'(bus.b_data), 0);
        chk("rst a_gnt",   32'(bus.a_gnt), 0);
        chk("rst b_gnt",   32'(bus.b_gnt), 0);

        // ---------------- boot walk, B held off ----------------
        drive(1'b0, 4'd0, 1'b1, 4'd9);
        rst = 1'b0;
        #1;
        chk("boot b_gnt pre", 32'(bus.b_gnt), 0);
        for (int k = 1; k <= DEPTH; k++) begin
            cyc();
            chk("boot rom_en",   32'(bus.rom_en), 1);
            chk("boot rom_addr", 32'(bus.rom_addr), 32'(k - 1));
            chk("boot b_gnt",    32'(bus.b_gnt), 0);
            chk("boot fin",      32'(bus.fin), 0);
        end
        cyc();
        chk("boot fin rise",  32'(bus.fin), 1);
        chk("boot csum",      32'(bus.csum), 'h10);
        chk("boot rom_en off", 32'(bus.rom_en), 0);
        chk("first run b_gnt", 32'(bus.b_gnt), 1);
        cyc();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        #1;
        chk("held b rom_en",   32'(bus.rom_en), 1);
        chk("held b rom_addr", 32'(bus.rom_addr), 9);
        chk("held b valid early", 32'(bus.b_valid), 0);
        cyc();
        chk("held b valid", 32'(bus.b_valid), 1);
        chk("held b data",  32'(bus.b_data), 'h0A);
        chk("held a valid", 32'(bus.a_valid), 0);
        cyc();
        chk("held b valid pulse", 32'(bus.b_valid), 0);
        chk("held b data hold",   32'(bus.b_data), 'h0A);
        cyc();

`ifdef GROM_ARB_PRIO_EN
        // ---------------- fixed priority ----------------
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive(1'b1, 4'd2, 1'b1, 4'd9);
            #1;
            chk("prio a_gnt", 32'(bus.a_gnt), 1);
            chk("prio b_gnt", 32'(bus.b_gnt), 0);
        end
        cyc();
        drive(1'b0, 4'd2, 1'b1, 4'd9);
        #1;
        chk("prio b_gnt on a drop", 32'(bus.b_gnt), 1);
        chk("prio a_gnt on a drop", 32'(bus.a_gnt), 0);
        cyc();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        repeat (3) cyc();
`else
        // ---------------- round-robin vector table ----------------
        //           ar br aa  ba  ag bg en av bv ad     bd
        tbl[0]  = mk(1, 1, 2,  9,  1, 0, 0, 0, 0, 8'h00, 8'h00);
        tbl[1]  = mk(1, 1, 2,  9,  0, 1, 1, 0, 0, 8'h00, 8'h00);
        tbl[2]  = mk(1, 1, 2,  9,  1, 0, 1, 1, 0, 8'h03, 8'h00);
        tbl[3]  = mk(1, 1, 2,  9,  0, 1, 1, 0, 1, 8'h00, 8'h0A);
        tbl[4]  = mk(1, 0, 5,  0,  1, 0, 1, 1, 0, 8'h03, 8'h00);
        tbl[5]  = mk(0, 0, 0,  0,  0, 0, 1, 0, 1, 8'h00, 8'h0A);
        tbl[6]  = mk(0, 0, 0,  0,  0, 0, 0, 1, 0, 8'h06, 8'h00);
        tbl[7]  = mk(0, 1, 0,  0,  0, 1, 0, 0, 0, 8'h00, 8'h00);
        tbl[8]  = mk(1, 1, 15, 3,  1, 0, 1, 0, 0, 8'h00, 8'h00);
        tbl[9]  = mk(0, 1, 0,  3,  0, 1, 1, 0, 1, 8'h00, 8'h01);
        tbl[10] = mk(1, 1, 7,  4,  1, 0, 1, 1, 0, 8'h10, 8'h00);
        tbl[11] = mk(0, 0, 0,  0,  0, 0, 1, 0, 1, 8'h00, 8'h04);
        tbl[12] = mk(0, 0, 0,  0,  0, 0, 0, 1, 0, 8'h08, 8'h00);
        tbl[13] = mk(0, 0, 0,  0,  0, 0, 0, 0, 0, 8'h00, 8'h00);
        for (int i = 0; i < 14; i++) begin
            cyc();
            drive(tbl[i].ar, tbl[i].aa, tbl[i].br, tbl[i].ba);
            #1;
            chk($sformatf("vec%0d a_gnt", i),   32'(bus.a_gnt),   32'(tbl[i].eag));
            chk($sformatf("vec%0d b_gnt", i),   32'(bus.b_gnt),   32'(tbl[i].ebg));
            chk($sformatf("vec%0d rom_en", i),  32'(bus.rom_en),  32'(tbl[i].een));
            chk($sformatf("vec%0d a_valid", i), 32'(bus.a_valid), 32'(tbl[i].eav));
            chk($sformatf("vec%0d b_valid", i), 32'(bus.b_valid), 32'(tbl[i].ebv));
            if (tbl[i].eav) chk($sformatf("vec%0d a_data", i), 32'(bus.a_data), 32'(tbl[i].ead));
            if (tbl[i].ebv) chk($sformatf("vec%0d b_data", i), 32'(bus.b_data), 32'(tbl[i].ebd));
        end
`endif

        // ---------------- reset during RUN drops the in-flight read ----------------
        cyc();
        drive(1'b1, 4'd5, 1'b0, 4'd0);
        #1;
        chk("runrst a_gnt", 32'(bus.a_gnt), 1);
        cyc();
        rst = 1'b1;
        #1;
        chk("runrst rom_en",     32'(bus.rom_en), 1);
        chk("runrst gnt forced", 32'(bus.a_gnt), 0);
        cyc();
        drive(1'b0, 4'd0, 1'b0, 4'd0);
        chk("runrst a_valid", 32'(bus.a_valid), 0);
        chk("runrst rom_en0", 32'(bus.rom_en), 0);
        chk("runrst fin",     32'(bus.fin), 0);
        chk("runrst csum",    32'(bus.csum), 0);
        cyc();
        chk("runrst a_valid late", 32'(bus.a_valid), 0);
        rst = 1'b0;

        // ---------------- reset at boot edge 7 ----------------
        repeat (6) cyc();
        chk("midboot addr5", 32'(bus.rom_addr), 5);
        rst = 1'b1;
        cyc();
        chk("midboot fin",      32'(bus.fin), 0);
        chk("midboot csum",     32'(bus.csum), 0);
        chk("midboot rom_en",   32'(bus.rom_en), 0);
        chk("midboot rom_addr", 32'(bus.rom_addr), 0);
        rst = 1'b0;
        cyc();
        chk("reboot rom_en",   32'(bus.rom_en), 1);
        chk("reboot rom_addr", 32'(bus.rom_addr), 0);
        repeat (15) cyc();
        chk("reboot fin edge16",  32'(bus.fin), 0);
        chk("reboot addr edge16", 32'(bus.rom_addr), 15);
        cyc();
        chk("reboot fin edge17",  32'(bus.fin), 1);
        chk("reboot csum",        32'(bus.csum), 'h10);

        // ---------------- randomized traffic vs reference model ----------------
        for (int round = 0; round < 3; round++) begin
            rst = 1'b1;
            drive(1'b0, 4'd0, 1'b0, 4'd0);
            for (int i = 0; i < 2**AW; i++) rom[i] = 8'($urandom);
            mcsum = '0;
            for (int i = 0; i < DEPTH; i++) mcsum ^= rom[i];
            m_last = 1'b1;
            pend.delete();
            repeat (2) cyc();
            rst = 1'b0;
            for (int i = 0; i < 40 && !bus.fin; i++) cyc();
            chk("rnd fin", 32'(bus.fin), 1);
            chk("rnd csum", 32'(bus.csum), 32'(mcsum));

            ar = 1'b0; br = 1'b0; aa = '0; ba = '0;
            for (int n = 0; n < 300; n++) begin
                if (n != 0) cyc();
                drive(ar, aa, br, ba);
                #1;
                exp_grant(ar, br, ega, egb);
                chk("rnd a_gnt", 32'(bus.a_gnt), 32'(ega));
                chk("rnd b_gnt", 32'(bus.b_gnt), 32'(egb));
                eva = 1'b0; evb = 1'b0; ead = '0; ebd = '0;
                while (pend.size() > 0 && pend[0].due == n) begin
                    r = pend.pop_front();
                    if (r.side) begin evb = 1'b1; ebd = r.data; end
                    else        begin eva = 1'b1; ead = r.data; end
                end
                chk("rnd a_valid", 32'(bus.a_valid), 32'(eva));
                chk("rnd b_valid", 32'(bus.b_valid), 32'(evb));
                if (eva) chk("rnd a_data", 32'(bus.a_data), 32'(ead));
                if (evb) chk("rnd b_data", 32'(bus.b_data), 32'(ebd));
                if (ega) begin
                    pend.push_back('{side: 1'b0, data: rom[aa], due: n + 2});
                    m_last = 1'b0;
                end
                if (egb) begin
                    pend.push_back('{side: 1'b1, data: rom[ba], due: n + 2});
                    m_last = 1'b1;
                end
                // Requesters: hold until granted, then drop or re-request.
                if (bus.a_gnt) begin
                    ar = 1'($urandom_range(0, 1));
                    aa = 4'($urandom);
                end else if (!ar) begin
                    ar = ($urandom_range(0, 9) < 4);
                    aa = 4'($urandom);
                end
                if (bus.b_gnt) begin
                    br = 1'($urandom_range(0, 1));
                    ba = 4'($urandom);
                end else if (!br) begin
                    br = ($urandom_range(0, 9) < 4);
                    ba = 4'($urandom);
                end
            end
            chk("rnd drained", 32'(pend.size() <= 2), 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
